// File: rtl/md_sched_pkg.sv
// Shared encodings for the multiply/divide scheduler: FSM states, op_sel bit
// positions, the divide-by-zero quotient and a two's-complement magnitude helper.
package md_sched_pkg;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_DIV  = 2'd1;
  localparam logic [1:0] MD_MUL  = 2'd2;
  localparam logic [1:0] MD_DONE = 2'd3;

  // op_sel is one-hot {div, divu, mult, multu}
  localparam int unsigned OP_DIV   = 3;
  localparam int unsigned OP_DIVU  = 2;
  localparam int unsigned OP_MULT  = 1;
  localparam int unsigned OP_MULTU = 0;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_sched_div_iter.sv
// Iterative radix-2 restoring divider (one quotient bit per cycle, 32 cycles).
// With MD_MUL_ITER_EN it also runs a 32-step shift-add multiply on the same registers.
module div_iter
  import md_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
`ifdef MD_MUL_ITER_EN
  input  logic        mul,
`endif
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        done,
  output logic [63:0] result
);

  logic [31:0] rem_q, quot_q, dvs_q;
  logic [4:0]  cnt_q;
  logic        active_q, neg_q_q, neg_r_q;
  logic        sign_a, sign_b;

  logic [32:0] r33, sub33;
  logic        ge;
  logic [31:0] rem_n, quot_n;
`ifdef MD_MUL_ITER_EN
  logic        mul_q;
  logic [32:0] sum33;
  logic [63:0] prod;
`endif

  assign sign_a = is_signed & op_a[31];
  assign sign_b = is_signed & op_b[31];

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= '0;
      quot_q   <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
`ifdef MD_MUL_ITER_EN
      mul_q    <= 1'b0;
`endif
    end else if (start) begin
      rem_q    <= '0;
      quot_q   <= mag32(op_a, sign_a);
      dvs_q    <= mag32(op_b, sign_b);
      cnt_q    <= '0;
      active_q <= 1'b1;
      neg_q_q  <= sign_a ^ sign_b;
      neg_r_q  <= sign_a;
`ifdef MD_MUL_ITER_EN
      mul_q    <= mul;
`endif
    end else if (active_q) begin
      rem_q  <= rem_n;
      quot_q <= quot_n;
      cnt_q  <= cnt_q + 5'd1;
      if (cnt_q == 5'd31)
        active_q <= 1'b0;
    end
  end

  // Divide: quot_q doubles as the dividend shifter; its MSB feeds the remainder.
  // Multiply: {rem_q, quot_q} is the product shifter, quot_q[0] selects the add.
  always_comb begin
    r33    = {rem_q, quot_q[31]};
    sub33  = r33 - {1'b0, dvs_q};
    ge     = (r33 >= {1'b0, dvs_q});
    rem_n  = ge ? sub33[31:0] : r33[31:0];
    quot_n = {quot_q[30:0], ge};
    result = {mag32(rem_n, neg_r_q), mag32(quot_n, neg_q_q)};
`ifdef MD_MUL_ITER_EN
    sum33 = {1'b0, rem_q} + {1'b0, dvs_q & {32{quot_q[0]}}};
    prod  = '0;
    if (mul_q) begin
      rem_n  = sum33[32:1];
      quot_n = {sum33[0], quot_q[31:1]};
      prod   = {rem_n, quot_n};
      result = neg_q_q ? (~prod + 64'd1) : prod;
    end
`endif
  end

  assign done = active_q && (cnt_q == 5'd31);

endmodule

// File: rtl/md_sched.sv
// EX-stage multiply/divide scheduler: FSM, operand latch, multiplier, HI/LO regs.
// Define MD_MUL_ITER_EN to run MULT/MULTU through the iterative unit (no '*').
module md_sched
  import md_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op_sel,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        ex_hold,
  output logic        stallreq,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy
);

  logic [1:0]  state_q;
  logic [31:0] hi_q, lo_q;
  logic        is_div, is_mul, is_signed, div_zero, accept, start;
  logic        iter_done;
  logic [63:0] iter_res;

  assign is_div    = op_sel[OP_DIV] | op_sel[OP_DIVU];
  assign is_mul    = op_sel[OP_MULT] | op_sel[OP_MULTU];
  assign is_signed = op_sel[OP_DIV] | op_sel[OP_MULT];
  assign div_zero  = is_div && (src2 == '0);
  assign accept    = (state_q == MD_IDLE) && op_valid && (is_div || is_mul);

`ifdef MD_MUL_ITER_EN
  assign start = accept && !div_zero;
`else
  assign start = accept && is_div && !div_zero;

  logic [31:0] a_q, b_q;
  logic        msgn_q;
  logic [63:0] prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      msgn_q <= 1'b0;
    end else if (accept && !is_div) begin
      a_q    <= src1;
      b_q    <= src2;
      msgn_q <= op_sel[OP_MULT];
    end
  end

  // Low 64 bits of the extended operands' product equal the 33x33 product.
  assign prod = (msgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q}) *
                (msgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q});
`endif

  div_iter u_div_iter (
    .clk       (clk),
    .rst       (rst),
`ifdef MD_MUL_ITER_EN
    .mul       (!is_div),
`endif
    .start     (start),
    .is_signed (is_signed),
    .op_a      (src1),
    .op_b      (src2),
    .done      (iter_done),
    .result    (iter_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (accept) begin
            if (div_zero) begin
              hi_q    <= src1;
              lo_q    <= DIV0_QUOT;
              state_q <= MD_DONE;
            end else if (is_div) begin
              state_q <= MD_DIV;
            end else begin
              state_q <= MD_MUL;
            end
          end
        end
        MD_DIV: begin
          if (iter_done) begin
            hi_q    <= iter_res[63:32];
            lo_q    <= iter_res[31:0];
            state_q <= MD_DONE;
          end
        end
        MD_MUL: begin
`ifdef MD_MUL_ITER_EN
          if (iter_done) begin
            hi_q    <= iter_res[63:32];
            lo_q    <= iter_res[31:0];
            state_q <= MD_DONE;
          end
`else
          hi_q    <= prod[63:32];
          lo_q    <= prod[31:0];
          state_q <= MD_DONE;
`endif
        end
        MD_DONE: begin
          // No restart from DONE: a held instruction must not execute twice.
          if (!ex_hold)
            state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign stallreq = (accept && !div_zero) || (state_q == MD_DIV) || (state_q == MD_MUL);
  assign hilo_we  = (state_q == MD_DONE);
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign busy     = (state_q != MD_IDLE);

endmodule
